// File: rtl/voice_allocator_if.sv
// -----------------------------------------------------------------------------
// voice_allocator_if
//   Key-event handshake bus between the keyboard scanner (master) and the
//   voice allocator (slave).
//   key_valid  master -> slave  key event present, held until accepted
//   key_ready  slave  -> master event accepted on an edge with valid && ready
//   key_on     master -> slave  1 = press, 0 = release
//   note       master -> slave  0=A .. 11=G#, 4'hF = null
//   octave     master -> slave  octave 0..7
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface voice_allocator_if;
    logic       key_valid;
    logic       key_ready;
    logic       key_on;
    logic [3:0] note;
    logic [2:0] octave;

    modport master (output key_valid, output key_on, output note, output octave,
                    input  key_ready);
    modport slave  (input  key_valid, input  key_on, input  note, input  octave,
                    output key_ready);
endinterface

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//   Polyphonic note scheduler. Each accepted key event runs through
//   IDLE -> SCAN -> APPLY: the key is latched, compared against every voice
//   slot (match / lowest free / oldest), then the slot registers are updated
//   and either voice_start or dropped pulses for one cycle.
//   Optional feature macro: VOICE_STEAL_EN -- when defined, a press with all
//   slots busy steals the oldest slot; otherwise that press is dropped.
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low, clears all state
//   key_bus       key-event handshake (slave side)
//   voice_active  bit v = slot v sounding
//   voice_note    slot v note at [4v+3:4v], 4'hF when idle
//   voice_octave  slot v octave at [3v+2:3v], 0 when idle
//   voice_start   one-cycle pulse on the slot that was (re)assigned
//   dropped       one-cycle pulse when an accepted event changed nothing
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    voice_allocator_if.slave        key_bus,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [4*NUM_VOICES-1:0] voice_note,
    output logic [3*NUM_VOICES-1:0] voice_octave,
    output logic [NUM_VOICES-1:0]   voice_start,
    output logic                    dropped
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    // Saturating age increment: the counter sticks at its maximum.
    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        if (a == {AGE_W{1'b1}}) begin
            return a;
        end else begin
            return a + AGE_W'(1);
        end
    endfunction

    state_t                          state_r, state_nxt_s;
    logic                            key_ready_r, key_ready_nxt_s;

    logic                            key_on_r;
    logic [3:0]                      key_note_r;
    logic [2:0]                      key_oct_r;

    logic [NUM_VOICES-1:0]           active_r, active_nxt_s;
    logic [NUM_VOICES-1:0][3:0]      note_r, note_nxt_s;
    logic [NUM_VOICES-1:0][2:0]      oct_r, oct_nxt_s;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age_r, age_nxt_s;
    logic [NUM_VOICES-1:0]           voice_start_r, start_nxt_s;
    logic                            dropped_r, drop_nxt_s;

    logic                            match_s, match_r;
    logic [IDX_W-1:0]                match_idx_s, match_idx_r;
    logic                            free_s, free_r;
    logic [IDX_W-1:0]                free_idx_s, free_idx_r;
    logic [IDX_W-1:0]                oldest_idx_s, oldest_idx_r;
    logic [AGE_W-1:0]                oldest_age_s;

    logic                            hit_s;
    logic [IDX_W-1:0]                tgt_idx_s;

    wire accept_s = key_bus.key_valid && key_ready_r;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN:  state_nxt_s = ST_APPLY;
            ST_APPLY: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: ready only while the next state is IDLE.
    always_comb begin
        key_ready_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: key_ready_nxt_s = 1'b1;
            default: key_ready_nxt_s = 1'b0;
        endcase
    end

    // Registered ready flag; reset leaves the block ready to accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_ready_r <= 1'b1;
        end else begin
            key_ready_r <= key_ready_nxt_s;
        end
    end

    // Latch the key event on acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_on_r   <= 1'b0;
            key_note_r <= 4'hF;
            key_oct_r  <= 3'd0;
        end else if (accept_s) begin
            key_on_r   <= key_bus.key_on;
            key_note_r <= key_bus.note;
            key_oct_r  <= key_bus.octave;
        end
    end

    // Slot scan: first matching active slot, first inactive slot, and the
    // oldest slot (strict '>' keeps ties on the lowest index).
    always_comb begin
        match_s      = 1'b0;
        match_idx_s  = '0;
        free_s       = 1'b0;
        free_idx_s   = '0;
        oldest_idx_s = '0;
        oldest_age_s = age_r[0];
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!match_s && active_r[v] && (note_r[v] == key_note_r) &&
                (oct_r[v] == key_oct_r)) begin
                match_s     = 1'b1;
                match_idx_s = IDX_W'(v);
            end else begin
                match_s     = match_s;
            end
            if (!free_s && !active_r[v]) begin
                free_s     = 1'b1;
                free_idx_s = IDX_W'(v);
            end else begin
                free_s     = free_s;
            end
            if (age_r[v] > oldest_age_s) begin
                oldest_age_s = age_r[v];
                oldest_idx_s = IDX_W'(v);
            end else begin
                oldest_age_s = oldest_age_s;
            end
        end
    end

    // Capture scan results at the end of SCAN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_r      <= 1'b0;
            match_idx_r  <= '0;
            free_r       <= 1'b0;
            free_idx_r   <= '0;
            oldest_idx_r <= '0;
        end else if (state_r == ST_SCAN) begin
            match_r      <= match_s;
            match_idx_r  <= match_idx_s;
            free_r       <= free_s;
            free_idx_r   <= free_idx_s;
            oldest_idx_r <= oldest_idx_s;
        end
    end

    // APPLY decision: pick the target slot for a press, clear on a release,
    // or flag the event as dropped. Outside APPLY nothing changes.
    always_comb begin
        active_nxt_s = active_r;
        note_nxt_s   = note_r;
        oct_nxt_s    = oct_r;
        age_nxt_s    = age_r;
        start_nxt_s  = '0;
        drop_nxt_s   = 1'b0;
        hit_s        = 1'b0;
        tgt_idx_s    = '0;
        if (state_r == ST_APPLY) begin
            if (key_note_r > 4'd11) begin
                drop_nxt_s = 1'b1;
            end else if (key_on_r) begin
                if (match_r) begin
                    hit_s     = 1'b1;
                    tgt_idx_s = match_idx_r;
                end else if (free_r) begin
                    hit_s     = 1'b1;
                    tgt_idx_s = free_idx_r;
                end else begin
`ifdef VOICE_STEAL_EN
                    hit_s     = 1'b1;
                    tgt_idx_s = oldest_idx_r;
`else
                    drop_nxt_s = 1'b1;
`endif
                end
                if (hit_s) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IDX_W'(v) == tgt_idx_s) begin
                            active_nxt_s[v] = 1'b1;
                            note_nxt_s[v]   = key_note_r;
                            oct_nxt_s[v]    = key_oct_r;
                            age_nxt_s[v]    = '0;
                            start_nxt_s[v]  = 1'b1;
                        end else if (active_r[v]) begin
                            age_nxt_s[v]    = age_inc(age_r[v]);
                        end else begin
                            age_nxt_s[v]    = age_r[v];
                        end
                    end
                end else begin
                    start_nxt_s = '0;
                end
            end else begin
                if (match_r) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IDX_W'(v) == match_idx_r) begin
                            active_nxt_s[v] = 1'b0;
                            note_nxt_s[v]   = 4'hF;
                            oct_nxt_s[v]    = 3'd0;
                            age_nxt_s[v]    = '0;
                        end else begin
                            age_nxt_s[v]    = age_r[v];
                        end
                    end
                end else begin
                    drop_nxt_s = 1'b1;
                end
            end
        end else begin
            drop_nxt_s = 1'b0;
        end
    end

    // Slot state and one-cycle result pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_r      <= '0;
            note_r        <= {NUM_VOICES{4'hF}};
            oct_r         <= '0;
            age_r         <= '0;
            voice_start_r <= '0;
            dropped_r     <= 1'b0;
        end else begin
            active_r      <= active_nxt_s;
            note_r        <= note_nxt_s;
            oct_r         <= oct_nxt_s;
            age_r         <= age_nxt_s;
            voice_start_r <= start_nxt_s;
            dropped_r     <= drop_nxt_s;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_flat
            assign voice_note[4*g +: 4]   = note_r[g];
            assign voice_octave[3*g +: 3] = oct_r[g];
        end
    endgenerate

    assign voice_active      = active_r;
    assign voice_start       = voice_start_r;
    assign dropped           = dropped_r;
    assign key_bus.key_ready = key_ready_r;

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
//   Directed scoreboard bench for voice_allocator (4 voices, 8-bit ages).
//   The driver pushes the hand-computed result of each accepted event; the
//   monitor pops and compares when key_ready returns high, which is the cycle
//   the registered result is presented. Steal-dependent expectations follow
//   the VOICE_STEAL_EN macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_voice_allocator;

    localparam int NV = 4;

    typedef struct {
        logic [3:0]  act;
        logic [15:0] note;
        logic [11:0] oct;
        logic [3:0]  start;
        logic        drop;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  voice_active;
    logic [15:0] voice_note;
    logic [11:0] voice_octave;
    logic [3:0]  voice_start;
    logic        dropped;

    voice_allocator_if kif();

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_bus      (kif),
        .voice_active (voice_active),
        .voice_note   (voice_note),
        .voice_octave (voice_octave),
        .voice_start  (voice_start),
        .dropped      (dropped)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] a, input logic [15:0] n,
                                input logic [11:0] o, input logic [3:0] s, input logic d);
        exp_t e;
        e.act = a; e.note = n; e.oct = o; e.start = s; e.drop = d;
        return e;
    endfunction

    // Monitor: result appears when key_ready rises; pulses must clear a cycle later.
    int low_cnt      = 0;
    bit prev_ready   = 1'b1;
    bit pending_clr  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            low_cnt     = 0;
            prev_ready  = 1'b1;
            pending_clr = 1'b0;
        end else begin
            if (pending_clr) begin
                check("pulse_clear", {27'd0, voice_start, dropped}, 32'd0);
                pending_clr = 1'b0;
            end
            if (kif.key_ready !== 1'b1) begin
                low_cnt++;
            end else if (!prev_ready) begin
                check("ready_low_cycles", low_cnt, 32'd2);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got active=%0h with empty queue", voice_active);
                end else begin
                    e = exp_q.pop_front();
                    check("voice_active", {28'd0, voice_active}, {28'd0, e.act});
                    check("voice_note",   {16'd0, voice_note},   {16'd0, e.note});
                    check("voice_octave", {20'd0, voice_octave}, {20'd0, e.oct});
                    check("voice_start",  {28'd0, voice_start},  {28'd0, e.start});
                    check("dropped",      {31'd0, dropped},      {31'd0, e.drop});
                end
                pending_clr = 1'b1;
                low_cnt     = 0;
            end
            prev_ready = (kif.key_ready === 1'b1);
        end
    end

    task automatic send(input logic on, input logic [3:0] n, input logic [2:0] o, input exp_t e);
        int waited;
        @(negedge clk);
        kif.key_valid = 1'b1;
        kif.key_on    = on;
        kif.note      = n;
        kif.octave    = o;
        waited = 0;
        while (kif.key_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (kif.key_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=%b expected 1", kif.key_ready);
            kif.key_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(e);
            #1 kif.key_valid = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},  {31'd0, kif.key_ready}, 32'd1);
        check({tag, "_active"}, {28'd0, voice_active},  32'd0);
        check({tag, "_note"},   {16'd0, voice_note},    32'h0000_FFFF);
        check({tag, "_octave"}, {20'd0, voice_octave},  32'd0);
        check({tag, "_start"},  {28'd0, voice_start},   32'd0);
        check({tag, "_dropped"},{31'd0, dropped},       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_on    = 1'b0;
        kif.note      = 4'hF;
        kif.octave    = 3'd0;

        // 1: reset values
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_reset_values("reset");

        // 2: two presses fill slots 0 and 1
        send(1'b1, 4'd0, 3'd4, mk(4'b0001, 16'hFFF0, 12'h004, 4'b0001, 1'b0));
        send(1'b1, 4'd4, 3'd4, mk(4'b0011, 16'hFF40, 12'h024, 4'b0010, 1'b0));
        drain();

        // 3: retrigger, then release
        do_reset();
        send(1'b1, 4'd0, 3'd4, mk(4'b0001, 16'hFFF0, 12'h004, 4'b0001, 1'b0));
        send(1'b1, 4'd0, 3'd4, mk(4'b0001, 16'hFFF0, 12'h004, 4'b0001, 1'b0));
        send(1'b0, 4'd0, 3'd4, mk(4'b0000, 16'hFFFF, 12'h000, 4'b0000, 1'b0));
        drain();

        // 4: fill all slots, then press with no free slot
        do_reset();
        send(1'b1, 4'd0, 3'd4, mk(4'b0001, 16'hFFF0, 12'h004, 4'b0001, 1'b0));
        send(1'b1, 4'd2, 3'd4, mk(4'b0011, 16'hFF20, 12'h024, 4'b0010, 1'b0));
        send(1'b1, 4'd3, 3'd4, mk(4'b0111, 16'hF320, 12'h124, 4'b0100, 1'b0));
        send(1'b1, 4'd5, 3'd4, mk(4'b1111, 16'h5320, 12'h924, 4'b1000, 1'b0));
`ifdef VOICE_STEAL_EN
        send(1'b1, 4'd7,  3'd4, mk(4'b1111, 16'h5327, 12'h924, 4'b0001, 1'b0));
        send(1'b1, 4'd9,  3'd2, mk(4'b1111, 16'h5397, 12'h914, 4'b0010, 1'b0));
        send(1'b0, 4'd3,  3'd4, mk(4'b1011, 16'h5F97, 12'h814, 4'b0000, 1'b0));
        send(1'b1, 4'd11, 3'd4, mk(4'b1111, 16'h5B97, 12'h914, 4'b0100, 1'b0));
`else
        send(1'b1, 4'd7,  3'd4, mk(4'b1111, 16'h5320, 12'h924, 4'b0000, 1'b1));
        send(1'b1, 4'd9,  3'd2, mk(4'b1111, 16'h5320, 12'h924, 4'b0000, 1'b1));
        send(1'b0, 4'd3,  3'd4, mk(4'b1011, 16'h5F20, 12'h824, 4'b0000, 1'b0));
        send(1'b1, 4'd11, 3'd4, mk(4'b1111, 16'h5B20, 12'h924, 4'b0100, 1'b0));
`endif
        drain();

        // 5: invalid notes and unmatched releases are dropped
        do_reset();
        send(1'b1, 4'hF,  3'd4, mk(4'b0000, 16'hFFFF, 12'h000, 4'b0000, 1'b1));
        send(1'b1, 4'd12, 3'd4, mk(4'b0000, 16'hFFFF, 12'h000, 4'b0000, 1'b1));
        send(1'b0, 4'd2,  3'd3, mk(4'b0000, 16'hFFFF, 12'h000, 4'b0000, 1'b1));
        send(1'b1, 4'd11, 3'd7, mk(4'b0001, 16'hFFFB, 12'h007, 4'b0001, 1'b0));
        send(1'b0, 4'd11, 3'd6, mk(4'b0001, 16'hFFFB, 12'h007, 4'b0000, 1'b1));
        send(1'b0, 4'd11, 3'd7, mk(4'b0000, 16'hFFFF, 12'h000, 4'b0000, 1'b0));
        drain();

        // 6: reset during SCAN aborts; held event is re-accepted afterwards
        do_reset();
        @(negedge clk);
        kif.key_valid = 1'b1;
        kif.key_on    = 1'b1;
        kif.note      = 4'd0;
        kif.octave    = 3'd4;
        @(posedge clk);
        #1;
        check("scan_ready_low", {31'd0, kif.key_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        exp_q.push_back(mk(4'b0001, 16'hFFF0, 12'h004, 4'b0001, 1'b0));
        #1 kif.key_valid = 1'b0;
        drain();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
